// File: rtl/dmem_lane.sv
// dmem_lane: byte-addressed, word-organised data memory for the load/store path.
// Sub-word loads are sign or zero extended. A request is taken in one cycle
// (valid/ready) and its response is registered one cycle later. Misaligned,
// out-of-range and illegal-size accesses return an error and never write.
// After reset or on clear_i, an init sequencer zero-fills the whole array.
//
// State table:
//   state | meaning
//   INIT  | zero-fill word[cnt] each cycle, requests blocked
//   RUN   | serve load/store requests, clear_i re-enters INIT
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   clear_i         request a zero-fill of the whole array
//   req_valid_i     request present
//   req_ready_o     request can be accepted this cycle
//   req_we_i        1 = store, 0 = load
//   req_size_i      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i  load zero-extends when 1, sign-extends when 0
//   req_addr_i      byte address
//   req_wdata_i     store data, right-justified
//   rsp_valid_o     one-cycle pulse, response for last cycle's accept
//   rsp_rdata_o     load result, 0 for stores and errors
//   rsp_err_o       accepted request was misaligned, out of range or illegal
//   init_done_o     zero-fill has completed

module dmem_lane #(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_6000,
    parameter int          ADDR_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  init_done_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [ADDR_WIDTH-1:0] BASE_A     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   BASE_EXT   = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LIMIT_EXT  = BASE_EXT + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               init_done_q, init_done_d;

    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic               rsp_load_q;
    logic [1:0]         rsp_size_q;
    logic [1:0]         rsp_lane_q;
    logic               rsp_uns_q;

    logic [3:0][7:0]    mem_q [DEPTH_WORDS];
    logic [3:0][7:0]    rd_word_q;

    logic               accept;
    logic               req_err;
    logic               out_of_range;
    logic [ADDR_WIDTH:0] addr_ext;
    logic [IDX_W-1:0]   req_idx;
    logic [1:0]         lane;
    logic [3:0]         req_be;
    logic [31:0]        req_wlanes;

    logic [IDX_W-1:0]   mem_addr;
    logic [3:0]         mem_be;
    logic [3:0][7:0]    mem_wdata;
    logic               mem_re;

    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_data;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign req_ready_o = (state_q == RUN) && !clear_i;
    assign accept      = req_valid_i && req_ready_o;

    assign lane     = req_addr_i[1:0];
    assign addr_ext = {1'b0, req_addr_i};

    // Extra top bit keeps BASE + 4*DEPTH from wrapping near the top of the space.
    assign out_of_range = (addr_ext < BASE_EXT) || (addr_ext >= LIMIT_EXT);

    // BASE is word aligned, so the low two offset bits never borrow and the
    // word index can be formed from the index bits alone.
    assign req_idx = req_addr_i[IDX_W+1:2] - BASE_A[IDX_W+1:2];

    assign req_err = out_of_range
                  || (req_size_i == 2'b11)
                  || ((req_size_i == SZ_HALF) && lane[0])
                  || ((req_size_i == SZ_WORD) && (lane != 2'b00));

    always_comb begin
        req_be     = 4'b0000;
        req_wlanes = req_wdata_i;
        case (req_size_i)
            SZ_BYTE: begin
                req_be     = 4'b0001 << lane;
                req_wlanes = {4{req_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                req_be     = lane[1] ? 4'b1100 : 4'b0011;
                req_wlanes = {2{req_wdata_i[15:0]}};
            end
            SZ_WORD: begin
                req_be     = 4'b1111;
                req_wlanes = req_wdata_i;
            end
            default: begin
                req_be     = 4'b0000;
                req_wlanes = req_wdata_i;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory port mux: the init sequencer owns the port while in INIT
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = req_idx;
        mem_be    = 4'b0000;
        mem_wdata = req_wlanes;
        mem_re    = 1'b0;
        if (state_q == INIT) begin
            mem_addr  = cnt_q;
            mem_be    = 4'b1111;
            mem_wdata = '0;
        end else if (accept && !req_err) begin
            if (req_we_i) begin
                mem_be = req_be;
            end else begin
                mem_re = 1'b1;
            end
        end
    end

    // Single-port RAM with per-byte write enables; no reset on the array.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) begin
                mem_q[mem_addr][b] <= mem_wdata[b];
            end
        end
        if (mem_re) begin
            rd_word_q <= mem_q[mem_addr];
        end
    end

    // ------------------------------------------------------------------
    // Init / run sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (clear_i) begin
                    state_d     = INIT;
                    cnt_d       = '0;
                    init_done_d = 1'b0;
                end
            end
            default: begin
                state_d     = INIT;
                cnt_d       = '0;
                init_done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done_o = init_done_q;

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_size_q  <= 2'b00;
            rsp_lane_q  <= 2'b00;
            rsp_uns_q   <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && req_err;
            rsp_load_q  <= accept && !req_err && !req_we_i;
            if (accept) begin
                rsp_size_q <= req_size_i;
                rsp_lane_q <= lane;
                rsp_uns_q  <= req_unsigned_i;
            end
        end
    end

    // Lane select and extension act on the word the RAM registered last cycle.
    always_comb begin
        byte_sel  = rd_word_q[rsp_lane_q];
        half_sel  = rsp_lane_q[1] ? {rd_word_q[3], rd_word_q[2]} : {rd_word_q[1], rd_word_q[0]};
        load_data = rd_word_q;
        case (rsp_size_q)
            SZ_BYTE: load_data = {{24{!rsp_uns_q && byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{!rsp_uns_q && half_sel[15]}}, half_sel};
            default: load_data = rd_word_q;
        endcase
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    // Stores, errors and idle cycles return zero (also keeps reset value at 0).
    assign rsp_rdata_o = rsp_load_q ? load_data : 32'h0;

endmodule

// File: tb/tb_dmem_lane.sv
// Directed scoreboard bench for dmem_lane with a 16-word array at 0x6000.
module tb_dmem_lane;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    dmem_lane #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_6000),
        .ADDR_WIDTH  (32)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .init_done_o    (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request for one cycle; the expected response goes to the scoreboard.
    task automatic issue(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        check({name, " ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        sb.push_back('{exp_rdata, exp_err, name});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts edges until ready rises; zero-fill must take exactly DEPTH cycles.
    task automatic wait_init(input string name);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " init_cycles"}, 32'(n), 32'(DEPTH));
        check({name, " init_done"}, 32'(init_done), 32'd1);
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid 1 rdata %h expected no response", rsp_rdata);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, " rdata"}, rsp_rdata, mon_e.rdata);
                check({mon_e.name, " err"}, 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        #12;
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst init_done", 32'(init_done), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rdata", rsp_rdata, 32'h0);
        check("rst err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init("boot");

        issue("ld_w_6000", 1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 32'h0000_0000, 1'b0);

        // Word store then sign/zero extended byte loads back to back
        issue("st_w_6004",  1'b1, 2'b10, 1'b0, 32'h6004, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue("ld_b_6005s", 1'b0, 2'b00, 1'b0, 32'h6005, 32'h0, 32'hFFFF_FFBE, 1'b0);
        issue("ld_b_6005u", 1'b0, 2'b00, 1'b1, 32'h6005, 32'h0, 32'h0000_00BE, 1'b0);

        // Half store into the upper lanes
        issue("st_h_6006",  1'b1, 2'b01, 1'b0, 32'h6006, 32'hAAAA_1234, 32'h0, 1'b0);
        issue("ld_w_6004",  1'b0, 2'b10, 1'b0, 32'h6004, 32'h0, 32'h1234_BEEF, 1'b0);
        issue("ld_h_6004s", 1'b0, 2'b01, 1'b0, 32'h6004, 32'h0, 32'hFFFF_BEEF, 1'b0);
        issue("ld_h_6006u", 1'b0, 2'b01, 1'b1, 32'h6006, 32'h0, 32'h0000_1234, 1'b0);
        issue("ld_b_6007s", 1'b0, 2'b00, 1'b0, 32'h6007, 32'h0, 32'h0000_0012, 1'b0);
        issue("ld_h_6004u", 1'b0, 2'b01, 1'b1, 32'h6004, 32'h0, 32'h0000_BEEF, 1'b0);

        // Top word is in range
        issue("st_w_603c",  1'b1, 2'b10, 1'b0, 32'h603C, 32'hA5A5_0081, 32'h0, 1'b0);
        issue("ld_b_603cs", 1'b0, 2'b00, 1'b0, 32'h603C, 32'h0, 32'hFFFF_FF81, 1'b0);

        // Error cases: no writes, rdata forced to zero
        issue("st_w_6002",  1'b1, 2'b10, 1'b0, 32'h6002, 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue("ld_w_6002",  1'b0, 2'b10, 1'b0, 32'h6002, 32'h0, 32'h0, 1'b1);
        issue("ld_h_6001",  1'b0, 2'b01, 1'b0, 32'h6001, 32'h0, 32'h0, 1'b1);
        issue("ld_x_6000",  1'b0, 2'b11, 1'b0, 32'h6000, 32'h0, 32'h0, 1'b1);
        issue("ld_w_5ffc",  1'b0, 2'b10, 1'b0, 32'h5FFC, 32'h0, 32'h0, 1'b1);
        issue("ld_w_6040",  1'b0, 2'b10, 1'b0, 32'h6040, 32'h0, 32'h0, 1'b1);
        issue("st_w_6040",  1'b1, 2'b10, 1'b0, 32'h6040, 32'h1111_1111, 32'h0, 1'b1);
        issue("st_w_5ffc",  1'b1, 2'b10, 1'b0, 32'h5FFC, 32'h2222_2222, 32'h0, 1'b1);
        issue("chk_w_6000", 1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 32'h0000_0000, 1'b0);
        issue("chk_w_6004", 1'b0, 2'b10, 1'b0, 32'h6004, 32'h0, 32'h1234_BEEF, 1'b0);
        issue("chk_w_603c", 1'b0, 2'b10, 1'b0, 32'h603C, 32'h0, 32'hA5A5_0081, 1'b0);

        // In-flight load, then CLEAR together with a request that must be refused
        issue("inflight",   1'b0, 2'b10, 1'b0, 32'h6004, 32'h0, 32'h1234_BEEF, 1'b0);
        clear     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h6008;
        req_wdata = 32'h5555_5555;
        #1;
        check("clear ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        clear     = 1'b0;
        req_valid = 1'b0;
        check("clear init_done", 32'(init_done), 32'd0);
        check("clear ready_after", 32'(req_ready), 32'd0);
        wait_init("clear");
        issue("clr_w_6000", 1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 32'h0, 1'b0);
        issue("clr_w_6004", 1'b0, 2'b10, 1'b0, 32'h6004, 32'h0, 32'h0, 1'b0);
        issue("clr_w_6008", 1'b0, 2'b10, 1'b0, 32'h6008, 32'h0, 32'h0, 1'b0);
        issue("clr_w_603c", 1'b0, 2'b10, 1'b0, 32'h603C, 32'h0, 32'h0, 1'b0);

        // Reset in the middle of INIT restarts the full count
        issue("pre_st",     1'b1, 2'b10, 1'b0, 32'h6010, 32'h7777_8888, 32'h0, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst ready", 32'(req_ready), 32'd0);
        check("midrst init_done", 32'(init_done), 32'd0);
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        wait_init("midrst");
        issue("post_w_6010", 1'b0, 2'b10, 1'b0, 32'h6010, 32'h0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lane.md
Name: dmem_lane

Overview:
- Parametrised successor data memory for the core's load/store path: byte-addressed, word-organised block RAM with per-lane byte writes.
- Handles sub-word loads with correct sign/zero extension and a one-cycle valid/ready request with a registered response.
- Flags misaligned and out-of-range accesses with an error.
- Contains an init FSM that zero-fills the array after reset or on CLEAR, so software sees deterministic contents.

Parameters:
- DEPTH_WORDS, 16384, number of 32-bit words (64 kB default); power of two.
- BASE_ADDR, 32'h0000_6000, byte address of word 0; word aligned.
- ADDR_WIDTH, 32, width of REQ_ADDR.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- CLEAR  in  1  request a zero-fill of the whole array.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request this cycle.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0.
- REQ_ADDR  in  ADDR_WIDTH  byte address.
- REQ_WDATA  in  32  store data, right-justified.
- RSP_VALID  out  1  one-cycle pulse, response for the request accepted last cycle.
- RSP_RDATA  out  32  load result; 0 for stores and errors.
- RSP_ERR  out  1  accepted request was misaligned, out of range or illegal size.
- INIT_DONE  out  1  high once the zero-fill has completed.

Behaviour:
- Reset (RST_N low, async):
  - REQ_READY=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, INIT_DONE=0.
  - FSM enters INIT with the word counter at 0.
  - Array contents are not reset directly.
- FSM states:
  - INIT: writes 0 to word[cnt] each cycle and increments cnt. When cnt reaches DEPTH_WORDS-1, the last word is written, INIT_DONE is set and the FSM moves to RUN. INIT takes exactly DEPTH_WORDS cycles.
  - RUN: serves requests. CLEAR=1 moves the FSM to INIT on the next edge, clears INIT_DONE and resets cnt to 0.
  - CLEAR is ignored while in INIT.
  - Reset asserted mid-INIT restarts INIT from 0.
- REQ_READY = (state==RUN) && !CLEAR. This is combinational, so CLEAR wins over a simultaneous request.
- Accept: a request is accepted when REQ_VALID && REQ_READY. Back-to-back accepts, one per cycle, are allowed.
- Latency: RSP_VALID is asserted exactly 1 cycle after every accept, and RSP_RDATA/RSP_ERR are valid in that same cycle.
  - A response already in flight when CLEAR is taken is still delivered.
- Address decode:
  - off = REQ_ADDR - BASE_ADDR.
  - idx = off[log2(DEPTH_WORDS)+1:2].
  - Lane = REQ_ADDR[1:0].
- Error conditions:
  - REQ_ADDR < BASE_ADDR, or REQ_ADDR >= BASE_ADDR + 4*DEPTH_WORDS.
  - REQ_SIZE=11.
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - On error: no array write; response has RSP_ERR=1 and RSP_RDATA=0.
- Stores:
  - Byte writes WDATA[7:0] to lane addr[1:0].
  - Half writes WDATA[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Word writes all four lanes.
  - Untouched lanes are preserved (per-byte write enable, no read-modify-write).
  - Store response: RSP_RDATA=0, RSP_ERR=0.
- Loads:
  - Select the addressed byte or half from the word.
  - Extension is taken from the loaded data's MSB when REQ_UNSIGNED=0, and is zero when REQ_UNSIGNED=1.
  - Word loads ignore REQ_UNSIGNED.
- Read after write: a load accepted the cycle after a store to the same word returns the new data.
- The array must infer block RAM with byte-write enables.

Test Plan:
- Release reset with DEPTH_WORDS=16 -> REQ_READY=0 for 16 cycles, then INIT_DONE=1 and REQ_READY=1; a word load at 0x6000 returns 0x00000000.
- Word store 0xDEADBEEF at 0x6004, then on the next cycle byte loads at 0x6005 with REQ_UNSIGNED=0 and =1 -> 0xFFFFFFBE and 0x000000BE, each on consecutive RSP_VALID pulses.
- Half store 0x1234 at 0x6006 over 0xDEADBEEF -> word load at 0x6004 returns 0x1234BEEF; signed half load at 0x6004 returns 0xFFFFBEEF.
- Word load at 0x6002, half load at 0x6001, size 11 at 0x6000, and load at 0x5FFC and 0x6040 (DEPTH 16) -> each gives RSP_ERR=1 and RSP_RDATA=0; a preceding word store at 0x6002 leaves memory unchanged.
- CLEAR asserted in the same cycle as REQ_VALID after prior stores -> REQ_READY=0, the request is not accepted, INIT runs 16 cycles, and all words later read 0.
- RST_N pulsed low at INIT cycle 5 -> outputs immediately 0 and INIT restarts with a full 16-cycle count.
